// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-stage valid/ready pipeline with bubble collapse, global stall and per-stage flush.
// Define PIPE_SKID_EN to add a one-entry input skid register so in_ready comes straight from a flop.
module pipe_stage_chain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    localparam int OCC_W = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             stall,
    input  logic [DEPTH-1:0] flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] go;
    logic [DEPTH:0]   room;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] ld_data [DEPTH];
    logic             push0;
    logic [WIDTH-1:0] src0;

    // A stage has room when empty, flushed this edge, or moving on; evaluated from the output end.
    always_comb begin
        go          = '0;
        room        = '0;
        room[DEPTH] = out_ready;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            int unsigned i;
            i       = DEPTH - 1 - k;
            go[i]   = v[i] && !flush[i] && !stall && room[i+1];
            room[i] = !v[i] || flush[i] || go[i];
        end
    end

`ifdef PIPE_SKID_EN
    logic             skid_v;
    logic [WIDTH-1:0] skid_d;
    logic             take;

    assign in_ready = rst_n && !skid_v;
    assign take     = in_valid && in_ready;
    assign push0    = !stall && room[0] && (skid_v || take);
    assign src0     = skid_v ? skid_d : in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_v <= 1'b0;
            skid_d <= '0;
        end else if (skid_v) begin
            if (push0) skid_v <= 1'b0;
        end else if (take && !push0) begin
            skid_v <= 1'b1;
            skid_d <= in_data;
        end
    end
`else
    assign in_ready = rst_n && !stall && room[0];
    assign push0    = in_valid && in_ready;
    assign src0     = in_data;
`endif

    always_comb begin
        load       = '0;
        load[0]    = push0;
        ld_data[0] = src0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            load[i]    = go[i-1];
            ld_data[i] = d[i-1];
        end
    end

    // A load wins over a flush: flush only kills the item resident at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) d[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (load[i]) begin
                    v[i] <= 1'b1;
                    d[i] <= ld_data[i];
                end else if (go[i] || flush[i]) begin
                    v[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(v[i]);
`ifdef PIPE_SKID_EN
        occupancy = occupancy + OCC_W'(skid_v);
`endif
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed-vector bench for pipe_stage_chain (WIDTH=8, DEPTH=3); expectations are hand-derived.
module tb_pipe_stage_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
`ifdef PIPE_SKID_EN
    localparam int FULL = 4;
`else
    localparam int FULL = 3;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             stall;
    logic [DEPTH-1:0] flush;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [2:0]       occupancy;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q [$];
    int n_acc;

    logic [7:0] t1_in  [6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
    int         t1_ov  [6] = '{0, 0, 1, 1, 1, 0};
    logic [7:0] t1_od  [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    int         t1_occ [6] = '{1, 2, 3, 2, 1, 0};

    pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input int base, input int step);
        out_ready = 1'b0;
        for (int j = 0; j < n; j++) begin
            in_valid = 1'b1;
            in_data  = 8'(base + j * step);
            #1;
            check_eq("fill_rdy", in_ready, 1);
            exp_q.push_back(in_data);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        stall     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            if (out_valid) begin
                check_eq(tag, out_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
            tick();
        end
        check_eq({tag, "_left"}, exp_q.size(), 0);
        check_eq({tag, "_occ"}, occupancy, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        stall     = 1'b0;
        flush     = '0;
        out_ready = 1'b0;
        #1;
        check_eq("rst_ov", out_valid, 0);
        check_eq("rst_rdy", in_ready, 0);
        check_eq("rst_occ", occupancy, 0);
        check_eq("rst_od", out_data, 0);
        #12 rst_n = 1'b1;
        tick();

        // back-to-back stream, latency DEPTH-1 edges to visibility
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 3);
            in_data  = t1_in[c];
            tick();
            check_eq($sformatf("t1_ov%0d", c), out_valid, t1_ov[c]);
            check_eq($sformatf("t1_occ%0d", c), occupancy, t1_occ[c]);
            if (t1_ov[c] != 0) check_eq($sformatf("t1_od%0d", c), out_data, t1_od[c]);
        end

        // fill against backpressure, then drain in order
        out_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + n_acc);
            #1;
            if (in_ready) begin
                exp_q.push_back(in_data);
                n_acc++;
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        check_eq("t2_acc", n_acc, FULL);
        check_eq("t2_rdy", in_ready, 0);
        check_eq("t2_occ", occupancy, FULL);
        drain("t2_out");

        // stall freezes a full chain
        fill(3, 8'hC3, -17);
        out_ready = 1'b1;
        stall     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("t3_ov", out_valid, 1);
            check_eq("t3_od", out_data, 8'hC3);
            check_eq("t3_occ", occupancy, 3);
`ifndef PIPE_SKID_EN
            check_eq("t3_rdy", in_ready, 0);
`endif
        end
        stall = 1'b0;
        tick();
        check_eq("t3_rel_od", out_data, 8'hB2);
        check_eq("t3_rel_occ", occupancy, 2);
        void'(exp_q.pop_front());
        drain("t3_out");

        // flush middle stage; stage 0 item moves into the vacated slot
        fill(3, 8'h51, 1);
        flush = 3'b010;
        tick();
        flush = '0;
        check_eq("t4_occ", occupancy, 2);
        check_eq("t4_od", out_data, 8'h51);
        exp_q.delete(1);
        drain("t4_out");

        // lone item collapses to the last stage, then last-stage flush
        fill(1, 8'h66, 0);
        tick();
        check_eq("t5_ov_e2", out_valid, 0);
        tick();
        check_eq("t5_ov_e3", out_valid, 1);
        check_eq("t5_od", out_data, 8'h66);
        check_eq("t5_occ", occupancy, 1);
        out_ready = 1'b1;
        flush     = 3'b100;
        tick();
        flush = '0;
        check_eq("t5_fl_ov", out_valid, 0);
        check_eq("t5_fl_occ", occupancy, 0);
        exp_q.delete();
        tick();
        check_eq("t5_idle_ov", out_valid, 0);

        // simultaneous in and out on a full chain
        fill(3, 8'h81, 1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h84;
        #1;
        check_eq("t6_rdy", in_ready, 1);
        exp_q.push_back(8'h84);
        tick();
        in_valid = 1'b0;
        check_eq("t6_occ", occupancy, 3);
        check_eq("t6_od", out_data, 8'h82);
        void'(exp_q.pop_front());
        drain("t6_out");

        // flush still acts while stalled
        fill(2, 8'h91, 1);
        stall = 1'b1;
        flush = 3'b001;
        tick();
        flush = '0;
        check_eq("t7_occ", occupancy, 1);
        exp_q.delete(1);
        drain("t7_out");

        // asynchronous reset mid-stream, then clean restart
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + c);
            tick();
        end
        check_eq("t8_pre_ov", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t8_ov", out_valid, 0);
        check_eq("t8_rdy", in_ready, 0);
        check_eq("t8_occ", occupancy, 0);
        check_eq("t8_od", out_data, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        #1;
        check_eq("t8_rel_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check_eq("t8_first_occ", occupancy, 1);
        tick();
        tick();
        check_eq("t8_ov_e3", out_valid, 1);
        exp_q.push_back(8'h5A);
        drain("t8_out");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
